window5x5_s8: RTL and testbench

Sliding-window generator directly downstream of the s8 quantizer. It consumes the padded 32x32 signed-8 stream (valid / pixel / line_last / frame_last, no backpressure) and emits one 5x5 window per valid output position, 28x28 = 784 windows per frame. The output feeds the LeNet-5 conv1 MAC array. It uses four line buffers plus a 5x5 register window, and the output is registered.

---
 rtl/lenet_pkg.sv | 17 +
 rtl/window5x5_s8_linebuf.sv | 29 ++
 rtl/window5x5_s8.sv | 161 ++++++++++++++++
 tb/tb_window5x5_s8.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet-5 front-end constants and the window element indexing helper.
package lenet_pkg;

  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
  localparam int CONV_K = 5;
  localparam int PIX_W  = 8;

  // Width of the row/column position counters (covers 0..31).
  localparam int CNT_W  = 5;

  // Bit offset of window element (r,c) inside a flattened KxK window.
  function automatic int win_idx(input int r, input int c);
    return (r * CONV_K + c) * PIX_W;
  endfunction

endpackage

// File: rtl/window5x5_s8_linebuf.sv
// One line of pixel storage: synchronous write, asynchronous read, so a read
// and a write to the same address in one cycle return the old contents.
module linebuf_s8
  import lenet_pkg::*;
#(
  parameter int W  = IMG_W,
  parameter int DW = PIX_W
) (
  input  logic                 clk_in_100,
  input  logic                 wr_en,
  input  logic [$clog2(W)-1:0] addr,
  input  logic [DW-1:0]        wr_data,
  output logic [DW-1:0]        rd_data
);

  logic [DW-1:0] mem_q [W];

  assign rd_data = mem_q[addr];

  // Store the incoming pixel at the current column.
  // NOTE: storage arrays carry no reset; clearing them would force flops instead
  // of RAM, and stale contents are never emitted because of the row gate.
  always_ff @(posedge clk_in_100) begin
    if (wr_en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window5x5_s8.sv
// 5x5 sliding-window generator for the padded 32x32 s8 stream feeding conv1.
// Four chained line buffers supply the upper rows of each new window column,
// the live pixel supplies the bottom row; all outputs are registered.
module window5x5_s8
  import lenet_pkg::*;
#(
  parameter int W  = IMG_W,
  parameter int H  = IMG_H,
  parameter int K  = CONV_K,
  parameter int DW = PIX_W
) (
  input  logic              clk_in_100,
  input  logic              arst_n,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_pixel,
  input  logic              in_line_last,
  input  logic              in_frame_last,
  output logic              out_valid,
  output logic [K*K*DW-1:0] out_window,
  output logic [4:0]        out_row,
  output logic [4:0]        out_col,
  output logic              out_frame_last,
  output logic              err_sync
);

  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  logic             at_w_end, at_h_end, err;
  logic             emit;

  logic [DW-1:0]    lb_rd [K-1];
  logic [DW-1:0]    lb_wd [K-1];
  logic [DW-1:0]    new_col [K];
  logic [DW-1:0]    win_q [K][K];
  logic [DW-1:0]    win_d [K][K];

  logic              out_valid_q, out_valid_d;
  logic [K*K*DW-1:0] out_window_q, out_window_d;
  logic [4:0]        out_row_q, out_row_d, out_col_q, out_col_d;
  logic              out_frame_last_q, out_frame_last_d;
  logic              err_sync_q, err_sync_d;

  // Line buffer chain: lb0 takes the live pixel, lb(i) takes lb(i-1)'s old value.
  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    if (i == 0) begin : g_head
      assign lb_wd[i] = in_pixel;
    end else begin : g_tail
      assign lb_wd[i] = lb_rd[i-1];
    end
    linebuf_s8 #(.W(W), .DW(DW)) u_lb (
      .clk_in_100 (clk_in_100),
      .wr_en      (in_valid),
      .addr       (col_q),
      .wr_data    (lb_wd[i]),
      .rd_data    (lb_rd[i])
    );
  end

  // New window column, top (oldest line) to bottom (live pixel).
  always_comb begin
    for (int r = 0; r < K - 1; r++) begin
      new_col[r] = lb_rd[K-2-r];
    end
    new_col[K-1] = in_pixel;
  end

  assign at_w_end = (col_q == CNT_W'(W - 1));
  assign at_h_end = (row_q == CNT_W'(H - 1));
  assign emit     = in_valid && (row_q >= CNT_W'(K - 1)) && (col_q >= CNT_W'(K - 1));

  // Position counters and framing checks; frame_last outranks line_last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    col_d = col_q;
    row_d = row_q;
    err   = 1'b0;
    if (in_valid) begin
      if (in_frame_last) begin
        err   = !(at_w_end && at_h_end);
        col_d = '0;
        row_d = '0;
      end else if (in_line_last) begin
        err   = !at_w_end;
        col_d = '0;
        row_d = row_q + CNT_W'(1);
      end else if (at_w_end) begin
        err   = 1'b1;
        col_d = '0;
      end else begin
        col_d = col_q + CNT_W'(1);
      end
    end
  end

  // Shift the window left one column and insert the new column at the right.
  always_comb begin
    win_d = win_q;
    if (in_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][K-1] = new_col[r];
      end
    end
  end

  // Output registers: window and position hold their value between strobes.
  always_comb begin
    out_valid_d      = emit;
    out_frame_last_d = emit && in_frame_last && at_w_end && at_h_end;
    err_sync_d       = err;
    out_window_d     = out_window_q;
    out_row_d        = out_row_q;
    out_col_d        = out_col_q;
    if (emit) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          out_window_d[win_idx(r, c) +: DW] = win_d[r][c];
        end
      end
      out_row_d = row_q - CNT_W'(K - 1);
      out_col_d = col_q - CNT_W'(K - 1);
    end
  end

  // All state registers, cleared asynchronously.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_in_100 or negedge arst_n) begin
    if (!arst_n) begin
      col_q            <= '0;
      row_q            <= '0;
      win_q            <= '{default: '0};
      out_valid_q      <= 1'b0;
      out_window_q     <= '0;
      out_row_q        <= '0;
      out_col_q        <= '0;
      out_frame_last_q <= 1'b0;
      err_sync_q       <= 1'b0;
    end else begin
      col_q            <= col_d;
      row_q            <= row_d;
      win_q            <= win_d;
      out_valid_q      <= out_valid_d;
      out_window_q     <= out_window_d;
      out_row_q        <= out_row_d;
      out_col_q        <= out_col_d;
      out_frame_last_q <= out_frame_last_d;
      err_sync_q       <= err_sync_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_window     = out_window_q;
  assign out_row        = out_row_q;
  assign out_col        = out_col_q;
  assign out_frame_last = out_frame_last_q;
  assign err_sync       = err_sync_q;

endmodule

// File: tb/tb_window5x5_s8.sv
// Directed bench for window5x5_s8: ramp, bubbled, back-to-back, padded,
// short-line and mid-frame-reset frames, checked against a frame-array model.
module tb_window5x5_s8;
  import lenet_pkg::*;

  localparam int WB = CONV_K * CONV_K * PIX_W;

  logic          clk_in_100    = 1'b0;
  logic          arst_n        = 1'b0;
  logic          in_valid      = 1'b0;
  logic [7:0]    in_pixel      = '0;
  logic          in_line_last  = 1'b0;
  logic          in_frame_last = 1'b0;
  logic          out_valid;
  logic [WB-1:0] out_window;
  logic [4:0]    out_row;
  logic [4:0]    out_col;
  logic          out_frame_last;
  logic          err_sync;

  always #5 clk_in_100 = ~clk_in_100;

  window5x5_s8 dut (
    .clk_in_100     (clk_in_100),
    .arst_n         (arst_n),
    .in_valid       (in_valid),
    .in_pixel       (in_pixel),
    .in_line_last   (in_line_last),
    .in_frame_last  (in_frame_last),
    .out_valid      (out_valid),
    .out_window     (out_window),
    .out_row        (out_row),
    .out_col        (out_col),
    .out_frame_last (out_frame_last),
    .err_sync       (err_sync)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame images: index 0 is the first frame of a test, index 1 the next one.
  logic [7:0] fr [2][32][32];

  function automatic logic [WB-1:0] exp_win(input int f, input int r0, input int c0);
    logic [WB-1:0] w;
    w = '0;
    for (int r = 0; r < CONV_K; r++)
      for (int c = 0; c < CONV_K; c++)
        w[win_idx(r, c) +: PIX_W] = fr[f][r0+r][c0+c];
    return w;
  endfunction

  // Monitor-owned statistics and captures.
  int            n_win = 0, n_fl = 0, n_err = 0;
  int            mon_f = 0;
  int            prev_r = 0, prev_c = 0;
  bit            have_prev = 0;
  logic [WB-1:0] cap00 [2];
  logic [WB-1:0] cap2727 [2];

  // Driver-owned mode flags.
  bit chk_order  = 1;
  bit short_mode = 0;

  always @(negedge clk_in_100) begin
    int r, c, er, ec;
    if (!arst_n) begin
      mon_f     = 0;
      have_prev = 0;
    end else begin
      if (err_sync) n_err++;
      if (out_valid || out_frame_last)
        check("frame_last_pos", out_frame_last, out_valid && out_row == 5'd27 && out_col == 5'd27);
      if (out_valid) begin
        n_win++;
        r = int'(out_row);
        c = int'(out_col);
        if (chk_order) begin
          er = 0; ec = 0;
          if (have_prev) begin
            er = (prev_c == 27) ? prev_r + 1 : prev_r;
            ec = (prev_c == 27) ? 0 : prev_c + 1;
          end
          check("order_row", out_row, er);
          check("order_col", out_col, ec);
        end
        check("pos_range", (r > 27 || c > 27), 0);
        if (r <= 27 && c <= 27) begin
          if (short_mode && r >= 6 && r <= 10 && c >= 17)
            check("no_x", $isunknown(out_window), 0);
          else
            check("window", out_window, exp_win(mon_f, r, c));
          if (r == 0 && c == 0)   cap00[mon_f]   = out_window;
          if (r == 27 && c == 27) cap2727[mon_f] = out_window;
        end
        if (out_frame_last) begin
          n_fl++;
          mon_f     = mon_f ^ 1;
          have_prev = 0;
        end else begin
          prev_r    = r;
          prev_c    = c;
          have_prev = 1;
        end
      end
    end
  end

  task automatic idle(input int n);
    in_valid      = 1'b0;
    in_line_last  = 1'b0;
    in_frame_last = 1'b0;
    repeat (n) begin
      @(posedge clk_in_100);
      #1;
    end
  endtask

  task automatic send_pix(input logic [7:0] p, input bit ll, input bit fl);
    in_valid      = 1'b1;
    in_pixel      = p;
    in_line_last  = ll;
    in_frame_last = fl;
    @(posedge clk_in_100);
    #1;
    in_valid      = 1'b0;
    in_line_last  = 1'b0;
    in_frame_last = 1'b0;
  endtask

  // Sends frame f; optional random gaps, an early line_last at (short_row,
  // short_col), and an early stop just before pixel (stop_row, 10).
  task automatic send_frame(input int f, input int gap_max, input int short_row,
                            input int short_col, input int stop_row);
    for (int r = 0; r < 32; r++) begin
      for (int c = 0; c < 32; c++) begin
        if (r == stop_row && c == 10) return;
        if (r == short_row && c > short_col) break;
        if (gap_max > 0) idle($urandom_range(0, gap_max));
        send_pix(fr[f][r][c], (c == 31) || (r == short_row && c == short_col),
                 (r == 31 && c == 31));
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},  out_valid,      0);
    check({tag, "_window"}, out_window,     0);
    check({tag, "_row"},    out_row,        0);
    check({tag, "_col"},    out_col,        0);
    check({tag, "_fl"},     out_frame_last, 0);
    check({tag, "_err"},    err_sync,       0);
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    idle(1);
    check_reset_outputs("rst");
    idle(2);
    arst_n = 1'b1;
    idle(2);
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++) begin
        fr[0][r][c] = 8'((r * 32 + c) % 256);
        fr[1][r][c] = fr[0][r][c];
      end
  endtask

  int b_win, b_fl, b_err;

  task automatic snap();
    b_win = n_win;
    b_fl  = n_fl;
    b_err = n_err;
  endtask

  task automatic check_counts(input string tag, input int wins, input int fls, input int errs);
    check({tag, "_windows"},    n_win - b_win, wins);
    check({tag, "_frame_last"}, n_fl - b_fl,   fls);
    check({tag, "_err_sync"},   n_err - b_err, errs);
  endtask

  initial begin
    fill_ramp();

    // Reset state.
    do_reset();

    // Ramp frame, back-to-back pixels.
    snap();
    send_frame(0, 0, -1, -1, -1);
    idle(4);
    check_counts("ramp", 784, 1, 0);
    check("ramp_w00_e00",   cap00[0][7:0],     8'h00);
    check("ramp_w00_e04",   cap00[0][39:32],   8'h04);
    check("ramp_w00_e40",   cap00[0][167:160], 8'h80);
    check("ramp_w00_e44",   cap00[0][199:192], 8'h84);
    check("ramp_w2727_e00", cap2727[0][7:0],   8'h7b);
    check("ramp_w2727_e44", cap2727[0][199:192], 8'hff);

    // Bubbled ramp.
    do_reset();
    snap();
    send_frame(0, 5, -1, -1, -1);
    idle(4);
    check_counts("bubble", 784, 1, 0);
    check("bubble_w00_e44", cap00[0][199:192], 8'h84);

    // Two frames with zero gap, second inverted.
    do_reset();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        fr[1][r][c] = ~fr[0][r][c];
    snap();
    send_frame(0, 0, -1, -1, -1);
    send_frame(1, 0, -1, -1, -1);
    idle(4);
    check_counts("b2b", 1568, 2, 0);
    check("b2b_f2_w00_e00", cap00[1][7:0],     8'hff);
    check("b2b_f2_w00_e44", cap00[1][199:192], 8'h7b);

    // Padded frame with signed extremes.
    do_reset();
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        fr[0][r][c] = (r < 4 || r >= 28) ? 8'h00 : 8'((r * 7 + c * 13) % 256);
    fr[0][4][4]   = 8'h80;
    fr[0][27][27] = 8'h7f;
    fr[1] = fr[0];
    snap();
    send_frame(0, 0, -1, -1, -1);
    idle(4);
    check_counts("pad", 784, 1, 0);
    check("pad_w00_top4",      cap00[0][159:0],     '0);
    check("pad_w00_neg128",    cap00[0][199:192],   8'h80);
    check("pad_w2727_bottom4", cap2727[0][199:40],  '0);
    check("pad_w2727_pos127",  cap2727[0][7:0],     8'h7f);

    // Short line on row 10.
    do_reset();
    fill_ramp();
    short_mode = 1;
    chk_order  = 0;
    snap();
    send_frame(0, 0, 10, 20, -1);
    idle(4);
    short_mode = 0;
    chk_order  = 1;
    check_counts("short", 773, 1, 1);

    // Reset in the middle of row 15, then a full frame.
    do_reset();
    send_frame(0, 0, -1, -1, 15);
    arst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    idle(3);
    check_reset_outputs("midrst_hold");
    arst_n = 1'b1;
    idle(2);
    snap();
    send_frame(0, 0, -1, -1, -1);
    idle(4);
    check_counts("after_rst", 784, 1, 0);
    check("after_rst_w00_e44", cap00[0][199:192], 8'h84);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
